// File: rtl/enc_pwm_mixer_pkg.sv
// Shared defaults, detent direction type and the saturating/wrapping step
// arithmetic used by every encoder channel.
package enc_pwm_mixer_pkg;

    localparam int DEF_NUM_CH          = 3;
    localparam int DEF_PWM_W           = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PRESCALE        = 1;
    localparam int DEF_STEP            = 1;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } dir_e;

    // Applies one detent to a duty value of the given width. Values are carried
    // in 32 bits so the sum/difference never overflows before clamping/wrapping.
    function automatic logic [31:0] step_value(
        input logic [31:0] cur,
        input logic [31:0] step,
        input dir_e        dir,
        input logic        sat,
        input int          width
    );
        logic [31:0] max_val;
        logic [31:0] res;
        max_val = (32'd1 << width) - 32'd1;
        if (dir == DIR_CW) begin
            res = cur + step;
            if (res > max_val) begin
                res = sat ? max_val : (res & max_val);
            end
        end else begin
            if (step > cur) begin
                res = sat ? 32'd0 : ((cur - step) & max_val);
            end else begin
                res = cur - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/enc_pwm_mixer_channel.sv
// One encoder channel: two-flop synchroniser, A/B debouncers, A-rise detent
// decode and the duty value register with its load override.
module enc_channel
    import enc_pwm_mixer_pkg::*;
#(
    parameter int PWM_W           = DEF_PWM_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP            = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             sat_mode,
    input  logic             load_hit,
    input  logic [PWM_W-1:0] load_val,
    output logic [PWM_W-1:0] value
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Bit 0 carries phase A, bit 1 carries phase B.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [CNT_W-1:0] deb_cnt [2];
    logic             deb_a_prev;
    logic             detent;
    dir_e             dir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_a_prev <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1      <= {enc_b, enc_a};
            sync2      <= sync1;
            deb_a_prev <= deb[0];
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign detent = deb[0] & ~deb_a_prev;
    assign dir    = deb[1] ? DIR_CCW : DIR_CW;

    // A load on the same cycle as a detent wins and the detent is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load_hit) begin
            value <= load_val;
        end else if (detent) begin
            value <= PWM_W'(step_value(32'(value), 32'(STEP), dir, sat_mode, PWM_W));
        end
    end

endmodule

// File: rtl/enc_pwm_mixer.sv
// Multi-channel encoder/PWM mixer: per-channel encoder value registers plus a
// shared prescaled PWM counter and one registered comparator per channel.
module enc_pwm_mixer
    import enc_pwm_mixer_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int PWM_W           = DEF_PWM_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PRESCALE        = DEF_PRESCALE,
    parameter int STEP            = DEF_STEP,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       sat_mode,
    input  logic                    load_en,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [PWM_W-1:0]        load_val,
    output logic [NUM_CH*PWM_W-1:0] value_o,
    output logic [NUM_CH-1:0]       pwm_out
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NUM_CH-1:0] load_hit;
    logic [PRE_W-1:0]  pre_cnt;
    logic              pre_tick;
    logic [PWM_W-1:0]  pwm_cnt;

    // Out-of-range channel numbers simply match no channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_hit[i] = load_en && (load_ch == CH_W'(i));

        enc_channel #(
            .PWM_W           (PWM_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STEP            (STEP)
        ) u_channel (
            .clk      (clk),
            .reset_n  (reset_n),
            .enc_a    (enc_a[i]),
            .enc_b    (enc_b[i]),
            .sat_mode (sat_mode[i]),
            .load_hit (load_hit[i]),
            .load_val (load_val),
            .value    (value_o[i*PWM_W +: PWM_W])
        );
    end

    assign pre_tick = (pre_cnt == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (pre_tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Comparators read the live value registers, so duty changes apply on the next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= (value_o[i*PWM_W +: PWM_W] > pwm_cnt);
            end
        end
    end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Self-checking bench for enc_pwm_mixer: event-scheduled reference model with a
// per-cycle compare, plus literal checks and a PRESCALE=4 / STEP=16 second instance.
module tb_enc_pwm_mixer;

    localparam int NUM_CH = 3;
    localparam int DEB    = 4;
    localparam int LAT    = 2 + DEB + 1;
    localparam int MAXV   = 255;
    localparam int STEP   = 1;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [2:0]  enc_a    = '0;
    logic [2:0]  enc_b    = '0;
    logic [2:0]  sat_mode = '0;
    logic        load_en  = 1'b0;
    logic [1:0]  load_ch  = '0;
    logic [7:0]  load_val = '0;
    logic [23:0] value_o;
    logic [2:0]  pwm_out;

    logic [2:0]  enc_a2    = '0;
    logic [2:0]  enc_b2    = '0;
    logic [2:0]  sat_mode2 = '0;
    logic        load_en2  = 1'b0;
    logic [1:0]  load_ch2  = '0;
    logic [7:0]  load_val2 = '0;
    logic [23:0] value_o2;
    logic [2:0]  pwm_out2;

    int   total = 0;
    int   bad   = 0;
    bit   checking = 1'b0;
    int   mval [3];
    int   mcnt;
    int   edge_n;
    logic [2:0] mpwm;
    int   ev_edge [$];
    int   ev_ch   [$];
    bit   ev_up   [$];

    enc_pwm_mixer #(
        .NUM_CH(3), .PWM_W(8), .DEBOUNCE_CYCLES(4), .PRESCALE(1), .STEP(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .sat_mode(sat_mode), .load_en(load_en), .load_ch(load_ch),
        .load_val(load_val), .value_o(value_o), .pwm_out(pwm_out)
    );

    enc_pwm_mixer #(
        .NUM_CH(3), .PWM_W(8), .DEBOUNCE_CYCLES(4), .PRESCALE(4), .STEP(16)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a2), .enc_b(enc_b2),
        .sat_mode(sat_mode2), .load_en(load_en2), .load_ch(load_ch2),
        .load_val(load_val2), .value_o(value_o2), .pwm_out(pwm_out2)
    );

    always #5 clk = ~clk;

    function automatic int ref_step(int cur, bit up, bit sat);
        int r;
        r = up ? cur + STEP : cur - STEP;
        if (sat) begin
            if (r < 0) r = 0;
            if (r > MAXV) r = MAXV;
        end else begin
            r = ((r % 256) + 256) % 256;
        end
        return r;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advances one clock and moves the model to the state after that edge.
    task automatic tick();
        bit hit [3];
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            mpwm[i] = (mval[i] > mcnt);
            hit[i]  = load_en && (int'(load_ch) == i);
        end
        mcnt = (mcnt + 1) % 256;
        for (int j = ev_edge.size() - 1; j >= 0; j--) begin
            if (ev_edge[j] == edge_n) begin
                if (!hit[ev_ch[j]])
                    mval[ev_ch[j]] = ref_step(mval[ev_ch[j]], ev_up[j], sat_mode[ev_ch[j]]);
                ev_edge.delete(j);
                ev_ch.delete(j);
                ev_up.delete(j);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (hit[i]) mval[i] = int'(load_val);
        end
        #1;
    endtask

    task automatic idle_tick(bit rnd);
        if (rnd && $urandom_range(7) == 0) begin
            load_en  = 1'b1;
            load_ch  = 2'($urandom_range(3));
            load_val = 8'($urandom);
        end else begin
            load_en = 1'b0;
        end
        if (rnd && $urandom_range(15) == 0) sat_mode[$urandom_range(2)] ^= 1'b1;
        tick();
    endtask

    task automatic load(int ch, int val);
        load_en  = 1'b1;
        load_ch  = 2'(ch);
        load_val = 8'(val);
        tick();
        load_en = 1'b0;
    endtask

    task automatic load2(int ch, int val);
        load_en2  = 1'b1;
        load_ch2  = 2'(ch);
        load_val2 = 8'(val);
        tick();
        load_en2 = 1'b0;
    endtask

    task automatic rise_a(int ch, bit up);
        enc_a[ch] = 1'b1;
        ev_edge.push_back(edge_n + LAT);
        ev_ch.push_back(ch);
        ev_up.push_back(up);
    endtask

    task automatic apply_stimulus(int ch, bit up, bit rnd);
        enc_b[ch] = ~up;
        repeat (8) idle_tick(rnd);
        rise_a(ch, up);
        repeat (8) idle_tick(rnd);
        enc_a[ch] = 1'b0;
        repeat (8) idle_tick(rnd);
    endtask

    task automatic detent2(int ch, bit up);
        enc_b2[ch] = ~up;
        repeat (8) idle_tick(0);
        enc_a2[ch] = 1'b1;
        repeat (8) idle_tick(0);
        enc_a2[ch] = 1'b0;
        repeat (8) idle_tick(0);
    endtask

    task automatic do_reset();
        checking = 1'b0;
        enc_a = '0; enc_b = '0; load_en = 1'b0;
        enc_a2 = '0; enc_b2 = '0; load_en2 = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) mval[i] = 0;
        mcnt = 0; edge_n = 0; mpwm = '0;
        ev_edge.delete(); ev_ch.delete(); ev_up.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_value", value_o, 0);
        check_output("reset_pwm", pwm_out, 0);
        check_output("reset_value2", value_o2, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        checking = 1'b1;
    endtask

    // Every cycle, the live outputs must match the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++)
                check_output($sformatf("value_ch%0d", i), value_o[i*8 +: 8], mval[i]);
            check_output("pwm_out", pwm_out, mpwm);
        end
    end

    initial begin
        int hi0, hi1, found;

        do_reset();

        // Three CW detents on ch0, first one with exact landing time.
        enc_b[0] = 1'b0;
        repeat (8) idle_tick(0);
        rise_a(0, 1'b1);
        repeat (6) idle_tick(0);
        @(negedge clk) check_output("latency_before", value_o[7:0], 0);
        idle_tick(0);
        @(negedge clk) check_output("latency_after", value_o[7:0], 1);
        repeat (2) idle_tick(0);
        enc_a[0] = 1'b0;
        repeat (8) idle_tick(0);
        apply_stimulus(0, 1'b1, 1'b0);
        apply_stimulus(0, 1'b1, 1'b0);
        @(negedge clk) check_output("cw_three", value_o, 24'h000003);

        // Saturation at zero, then wrap below zero.
        sat_mode[1] = 1'b1;
        apply_stimulus(1, 1'b0, 1'b0);
        apply_stimulus(1, 1'b0, 1'b0);
        @(negedge clk) check_output("sat_floor", value_o[15:8], 0);
        sat_mode[1] = 1'b0;
        apply_stimulus(1, 1'b0, 1'b0);
        @(negedge clk) check_output("wrap_under", value_o[15:8], 255);

        // Saturation at the top.
        sat_mode[2] = 1'b1;
        load(2, 254);
        repeat (3) apply_stimulus(2, 1'b1, 1'b0);
        @(negedge clk) check_output("sat_ceiling", value_o[23:16], 255);

        // Short glitch ignored, bouncy edge counted once.
        enc_a[0] = 1'b1;
        repeat (3) idle_tick(0);
        enc_a[0] = 1'b0;
        repeat (10) idle_tick(0);
        @(negedge clk) check_output("glitch", value_o[7:0], 3);
        enc_a[0] = 1'b1; repeat (2) idle_tick(0);
        enc_a[0] = 1'b0; idle_tick(0);
        enc_a[0] = 1'b1; idle_tick(0);
        enc_a[0] = 1'b0; repeat (2) idle_tick(0);
        rise_a(0, 1'b1);
        repeat (10) idle_tick(0);
        enc_a[0] = 1'b0;
        repeat (8) idle_tick(0);
        @(negedge clk) check_output("bounce", value_o[7:0], 4);

        // Load colliding with a detent on the same edge, then an out-of-range load.
        repeat (8) idle_tick(0);
        rise_a(0, 1'b1);
        repeat (6) idle_tick(0);
        load(0, 8'h80);
        @(negedge clk) check_output("load_wins", value_o[7:0], 8'h80);
        repeat (2) idle_tick(0);
        enc_a[0] = 1'b0;
        repeat (8) idle_tick(0);
        load(3, 8'h55);
        repeat (2) idle_tick(0);
        @(negedge clk) check_output("load_ch3", value_o, 24'hFFFF80);

        // PWM duty over two full periods.
        load(0, 64);
        load(1, 0);
        repeat (3) idle_tick(0);
        hi0 = 0; hi1 = 0;
        repeat (512) begin
            idle_tick(0);
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
        end
        check_output("pwm_25pct", hi0, 128);
        check_output("pwm_zero", hi1, 0);

        // Random detents, loads and mode changes against the model.
        sat_mode = 3'($urandom);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(2) != 0) begin
                apply_stimulus($urandom_range(2), 1'($urandom), 1'b1);
            end else begin
                sat_mode = 3'($urandom);
                repeat (3) idle_tick(1);
            end
        end
        load_en = 1'b0;

        // Reset while the output is high.
        load(0, 200);
        found = 0;
        for (int n = 0; n < 300 && found == 0; n++) begin
            idle_tick(0);
            @(negedge clk);
            if (pwm_out[0] === 1'b1) found = 1;
        end
        check_output("pwm_high_before_reset", found, 1);
        checking = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_output("pwm_async_reset", pwm_out, 0);
        check_output("value_async_reset", value_o, 0);
        do_reset();

        // Second instance: STEP=16, PRESCALE=4.
        sat_mode2 = 3'b010;
        load2(0, 250);
        detent2(0, 1'b1);
        @(negedge clk) check_output("step16_wrap", value_o2[7:0], 10);
        load2(1, 250);
        detent2(1, 1'b1);
        @(negedge clk) check_output("step16_sat", value_o2[15:8], 255);
        load2(0, 1);
        repeat (3) idle_tick(0);
        hi0 = 0;
        repeat (2048) begin
            idle_tick(0);
            @(negedge clk);
            hi0 += int'(pwm_out2[0]);
        end
        check_output("prescale_period", hi0, 8);
        load2(0, 128);
        repeat (3) idle_tick(0);
        hi0 = 0;
        repeat (1024) begin
            idle_tick(0);
            @(negedge clk);
            hi0 += int'(pwm_out2[0]);
        end
        check_output("prescale_half", hi0, 512);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
